score_sequencer: RTL

Round controller for the pose-scoring datapath. It paces one scoring round of `NUM_FRAMES` pose frames. For each frame it launches the three DTW engines (upper, lower-left, lower-right), waits for all three to finish in any order, triggers the single-cycle score adder, and accumulates the per-frame score into a saturating round total. It sits between frame-capture logic and the host-visible score register.

---
 rtl/score_pkg.sv | 25 ++
 rtl/sat_accum.sv | 28 ++
 rtl/score_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the pose-scoring round controller.
// State encoding and engine indices used across the scoring slice.
package score_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        LAUNCH,
        WAIT_DTW,
        SUM,
        ACCUM,
        DONE,
        ERROR
    } seq_state_t;

    localparam int NUM_ENGINES = 3;
    localparam int ENG_U       = 0;
    localparam int ENG_LL      = 1;
    localparam int ENG_LR      = 2;

    function automatic logic is_idle(seq_state_t s);
        return (s == IDLE) || (s == DONE) || (s == ERROR);
    endfunction

endpackage

// File: rtl/sat_accum.sv
// Saturating accumulator with synchronous clear and enable.
// A carry out of the widened add pins the result at all-ones.
module sat_accum
    import score_pkg::*;
#(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] acc
);

    logic [DATA_WIDTH:0] sum;

    assign sum = {1'b0, acc} + {1'b0, din};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum[DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/score_sequencer.sv
// Round controller: paces frames through the three DTW engines
// and the score adder, accumulating a saturating round total.
module score_sequencer
    import score_pkg::*;
#(
    parameter int DATA_WIDTH     = 24,
    parameter int NUM_FRAMES     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              go,
    input  logic                              frame_ready,
    output logic                              frame_ack,
    output logic [2:0]                        dtw_start,
    input  logic [2:0]                        dtw_done,
    output logic                              score_start,
    input  logic [DATA_WIDTH-1:0]             score_in,
    output logic [DATA_WIDTH-1:0]             total,
    output logic [$clog2(NUM_FRAMES+1)-1:0]   frame_idx,
    output logic                              busy,
    output logic                              round_done,
    output logic                              timeout_err
);

    localparam int IW = $clog2(NUM_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] F_LAST = IW'(NUM_FRAMES);

    seq_state_t             state;
    logic [NUM_ENGINES-1:0] done_mask;
    logic [NUM_ENGINES-1:0] seen;
    logic [TW-1:0]          tcnt;
    logic [IW-1:0]          idx_nxt;
    logic                   go_ok;

    assign seen    = done_mask | dtw_done;
    assign idx_nxt = frame_idx + 1'b1;
    assign go_ok   = go && is_idle(state);

    // score_in is valid in ACCUM, one cycle after score_start
    sat_accum #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_acc (
        .clk (clk),
        .rst (rst),
        .clr (go_ok),
        .en  (state == ACCUM),
        .din (score_in),
        .acc (total)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            done_mask   <= '0;
            tcnt        <= '0;
            frame_idx   <= '0;
            frame_ack   <= 1'b0;
            dtw_start   <= '0;
            score_start <= 1'b0;
            round_done  <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_ack   <= 1'b0;
            dtw_start   <= '0;
            score_start <= 1'b0;
            round_done  <= 1'b0;
            unique case (state)
                IDLE, DONE, ERROR: begin
                    if (go) begin
                        state       <= WAIT_FRAME;
                        busy        <= 1'b1;
                        frame_idx   <= '0;
                        done_mask   <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                WAIT_FRAME: begin
                    if (frame_ready) begin
                        state     <= LAUNCH;
                        frame_ack <= 1'b1;
                        dtw_start <= '1;
                    end
                end
                LAUNCH: begin
                    done_mask <= '0;
                    tcnt      <= '0;
                    state     <= WAIT_DTW;
                end
                WAIT_DTW: begin
                    done_mask <= seen;
                    if (&seen) begin
                        state       <= SUM;
                        score_start <= 1'b1;
                    end else if (tcnt == T_LAST) begin
                        state       <= ERROR;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                SUM: begin
                    state <= ACCUM;
                end
                ACCUM: begin
                    frame_idx <= idx_nxt;
                    if (idx_nxt == F_LAST) begin
                        state      <= DONE;
                        round_done <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        state <= WAIT_FRAME;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
